// File: rtl/muladd_pkg.sv
// Shared types for the muladd scheduler: FSM state encoding and default width.
// Imported by the interface, the top and nothing else.
package muladd_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muladd_if.sv
// Requester/result bundle of the muladd scheduler.
// master: requesters + consumer (req, operands, out_ready); slave: scheduler.
interface muladd_if
  import muladd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = 2
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    ack;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic               out_id;
  logic [WIDTH:0]     out_sum;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output req, a0, b0, a1, b1, out_ready,
    input  ack, busy, out_valid, out_id,
    input  out_sum, out_product
  );

  modport slave (
    input  req, a0, b0, a1, b1, out_ready,
    output ack, busy, out_valid, out_id,
    output out_sum, out_product
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last.
// Ports: req, en (grant enable), last_grant (index) in; one-hot grant out.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/muladd_scheduler.sv
// Arbitrated a+b / a*b unit: one grant, WIDTH-cycle shift-add, held result.
// Ports: clk, rst (sync, active-high), bus (muladd_if.slave).
module muladd_scheduler
  import muladd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = 2
) (
  input  logic     clk,
  input  logic     rst,
  muladd_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  state_t             nstate;
  logic [NREQ-1:0]    grant;
  logic               arb_en;
  logic               last_grant;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;
  logic               id;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               last_bit;

  // Reset wins over a pending request, so no ack during rst.
  assign arb_en = (state == IDLE) && !rst;

  rr_arb2 u_arb (
    .req        (bus.req),
    .en         (arb_en),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign op_a     = grant[1] ? bus.a1 : bus.a0;
  assign op_b     = grant[1] ? bus.b1 : bus.b0;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    nstate          = state;
    bus.ack         = grant;
    bus.busy        = (state != IDLE);
    bus.out_valid   = (state == DONE);
    bus.out_id      = id;
    bus.out_sum     = sum;
    bus.out_product = acc;
    unique case (state)
      IDLE:    if (grant != '0) nstate = MUL;
      MUL:     if (last_bit) nstate = DONE;
      DONE:    if (bus.out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      mplier     <= '0;
      mcand      <= '0;
      acc        <= '0;
      sum        <= '0;
      id         <= 1'b0;
    end else begin
      state <= nstate;
      unique case (state)
        IDLE: begin
          if (grant != '0) begin
            id         <= grant[1];
            last_grant <= grant[1];
            mcand      <= {{WIDTH{1'b0}}, op_a};
            mplier     <= op_b;
            sum        <= {1'b0, op_a} + {1'b0, op_b};
            acc        <= '0;
            cnt        <= '0;
          end
        end
        MUL: begin
          // LSB-first: add the shifted multiplicand when the bit is set.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muladd_scheduler.md
MULADD_SCHEDULER -- requirements
Module: muladd_scheduler

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter NREQ, fixed at 2, number of requesters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester operation request; each bit held high until acked.
REQ-006 a0, b0  input  WIDTH each  requester 0 operands.
REQ-007 a1, b1  input  WIDTH each  requester 1 operands.
REQ-008 ack  output  NREQ  one-hot, one-cycle pulse; operands of that requester captured this edge.
REQ-009 busy  output  1  high in any state except IDLE.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result when high with out_valid.
REQ-012 out_id  output  1  index of requester owning the result.
REQ-013 out_sum  output  WIDTH+1  a+b, unsigned, no truncation.
REQ-014 out_product  output  2*WIDTH  a*b, unsigned, no truncation.

Function
REQ-015 FSM states SHALL be IDLE, MUL and DONE.
REQ-016 IDLE: when any req bit is high, the block SHALL grant one requester, pulse its ack for that cycle, capture its a/b, and go to MUL on the next edge.
REQ-017 Arbitration SHALL be round-robin: if both req bits are high, grant the requester other than last_grant; a single requester always wins.
REQ-018 last_grant SHALL update only on a grant.
REQ-019 out_sum SHALL be computed from the captured operands and held stable from capture until leaving DONE.
REQ-020 MUL SHALL perform shift-add multiplication: one multiplier bit per cycle, LSB first, over exactly WIDTH cycles tracked by a bit counter.
REQ-021 After the final MUL cycle the block SHALL enter DONE, with out_valid high exactly WIDTH edges after the accepting edge (8 for default).
REQ-022 DONE: out_valid, out_id, out_sum and out_product SHALL hold stable until out_valid && out_ready; the block then returns to IDLE on that edge.
REQ-023 No new grant SHALL occur in the DONE-exit cycle; the earliest next ack is the cycle after returning to IDLE.
REQ-024 req changes during MUL/DONE SHALL be ignored; a requester that drops req before ack is never granted.
REQ-025 Operand changes after ack SHALL NOT affect the result in flight.
REQ-026 Zero operands SHALL still take the full WIDTH cycles (fixed latency).
REQ-027 ack SHALL never be asserted outside IDLE, and never on more than one bit.

Reset
REQ-028 With rst high at an edge, state SHALL go to IDLE, out_valid=0, busy=0, ack=0, out_id=0, out_sum=0, out_product=0, bit counter=0, last_grant=1 (requester 0 first).
REQ-029 Reset mid-MUL or mid-DONE SHALL abandon the operation without emitting out_valid; rst SHALL override all other inputs.

Structure
REQ-030 State encoding enum and the WIDTH default SHALL reside in a shared package muladd_pkg.
REQ-031 The arbiter SHALL be a sub-module rr_arb2 (req, grant-enable, last_grant in; one-hot grant out); FSM and shift-add datapath stay in the top module.

Verification
REQ-032 Only req[0], a0=10, b0=99 -> ack=01 once; 8 edges later out_valid=1, out_id=0, out_sum=109, out_product=990.
REQ-033 Both req high after reset, a0=132,b0=33, a1=255,b1=255 -> first result id0 sum 165 product 4356; next result id1 sum 510 product 65025.
REQ-034 out_ready held low 5 cycles in DONE -> out_valid and all outputs stable throughout; one result consumed on the ready edge; busy=0 next cycle.
REQ-035 rst asserted on 4th MUL cycle -> next cycle all outputs at reset values, no out_valid ever; next req[1]-only operation completes with correct result.
REQ-036 a0=0,b0=0 -> latency still 8 edges, out_sum=0, out_product=0.
REQ-037 req[1] and req[0] both high for 4 back-to-back operations -> grants alternate 0,1,0,1; ack never two-hot or outside IDLE.
